// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared IEEE-754 single-precision field constants and the
//               control state encoding of the multicycle FP divider. The
//               field constants are common to the FP multiplier and divider.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int EXP_W = 8;      // exponent field width
    localparam int MAN_W = 23;     // stored mantissa field width
    localparam int BIAS  = 127;    // exponent bias

    // Largest finite exponent and all-ones mantissa used when saturating.
    localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFE;
    localparam logic [MAN_W-1:0] SAT_MANT = 23'h7FFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } div_state_t;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp_div_step.sv
`default_nettype none
// ============================================================================
// Module      : fp_div_step
// Description : One combinational restoring-division step. Compares the
//               partial remainder against the divisor significand, subtracts
//               when it fits, and shifts the remainder left for the next bit.
// Revision    : 1.0 - initial release
//
// Ports
//   i_r      [24:0] in   current partial remainder
//   i_mb     [23:0] in   divisor significand {1, mant}
//   o_qbit          out  quotient bit for this step
//   o_r_next [24:0] out  remainder for the next step (already shifted)
// ============================================================================
module fp_div_step
    import fp_pkg::*;
(
    input  logic [MAN_W+1:0] i_r,
    input  logic [MAN_W:0]   i_mb,
    output logic             o_qbit,
    output logic [MAN_W+1:0] o_r_next
);

    logic             w_ge;
    logic [MAN_W+1:0] w_sub;
    logic [MAN_W+1:0] w_sel;

    assign w_ge  = (i_r >= {1'b0, i_mb});
    assign w_sub = i_r - {1'b0, i_mb};
    // The selected remainder is always below MB < 2^24, so the shift never
    // loses a significant bit.
    assign w_sel    = w_ge ? w_sub : i_r;
    assign o_qbit   = w_ge;
    assign o_r_next = w_sel << 1;

endmodule : fp_div_step
`default_nettype wire

// File: rtl/fp_div_32.sv
`default_nettype none
// ============================================================================
// Module      : fp_div_32
// Description : Multicycle IEEE-754 single-precision divider (a / b).
//               Restoring mantissa division, one quotient bit per clock,
//               truncating rounding, denormal operands treated as zero,
//               no NaN/Inf input handling. start/busy/done handshake.
// Revision    : 1.0 - initial release
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   request, sampled only while idle
//   a     [31:0] in   dividend {sign, exp[7:0], mant[22:0]}
//   b     [31:0] in   divisor
//   busy         out  high from the accepting edge until done rises
//   done         out  one-cycle completion pulse
//   result[31:0] out  quotient, held until overwritten by the next operation
//   dz           out  divide by zero
//   ovf          out  exponent overflow, result saturated
//   unf          out  exponent underflow, result flushed to zero
// ============================================================================
module fp_div_32 #(
    parameter int QW   = 25,   // quotient bits: 24-bit significand + 1
    parameter int BIAS = 127   // exponent bias
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        dz,
    output logic        ovf,
    output logic        unf
);

    import fp_pkg::*;

    localparam int CW = $clog2(QW);
    localparam int RW = MAN_W + 2;   // remainder width

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    div_state_t          r_state;
    logic                r_sign;
    logic signed [9:0]   r_diff;
    logic [RW-1:0]       r_rem;
    logic [MAN_W:0]      r_mb;
    logic [QW-1:0]       r_q;
    logic [CW-1:0]       r_cnt;
    logic [31:0]         r_result;
    logic                r_busy;
    logic                r_done;
    logic                r_dz;
    logic                r_ovf;
    logic                r_unf;

    // ------------------------------------------------------------------
    // Operand decode (used only on the accepting edge)
    // ------------------------------------------------------------------
    logic                w_sign;
    logic [EXP_W-1:0]    w_ea;
    logic [EXP_W-1:0]    w_eb;
    logic                w_a_zero;
    logic                w_b_zero;
    logic signed [9:0]   w_diff;

    assign w_sign   = a[31] ^ b[31];
    assign w_ea     = a[30:23];
    assign w_eb     = b[30:23];
    assign w_a_zero = (w_ea == '0);   // denormals count as zero
    assign w_b_zero = (w_eb == '0);
    // Computed modulo 2^10 and read back as signed: the true range
    // -126..380 fits comfortably.
    assign w_diff   = $signed({2'b00, w_ea} - {2'b00, w_eb} + 10'(BIAS));

    // ------------------------------------------------------------------
    // Iterated restoring step
    // ------------------------------------------------------------------
    logic                w_qbit;
    logic [RW-1:0]       w_r_next;

    fp_div_step u_step (
        .i_r      (r_rem),
        .i_mb     (r_mb),
        .o_qbit   (w_qbit),
        .o_r_next (w_r_next)
    );

    // ------------------------------------------------------------------
    // Normalisation and range handling of the finished quotient
    // ------------------------------------------------------------------
    logic                w_norm_hi;
    logic [MAN_W-1:0]    w_mant;
    logic signed [9:0]   w_exp;
    logic                w_ovf;
    logic                w_unf;
    logic [31:0]         w_norm_result;

    // Quotient lies in [0.5, 2): its top bit says whether it is >= 1.
    assign w_norm_hi = r_q[QW-1];
    assign w_mant    = w_norm_hi ? r_q[MAN_W:1] : r_q[MAN_W-1:0];
    assign w_exp     = w_norm_hi ? r_diff : (r_diff - 10'sd1);
    assign w_ovf     = (w_exp >= 10'sd255);
    assign w_unf     = (w_exp <= 10'sd0);

    always_comb begin
        w_norm_result = {r_sign, w_exp[EXP_W-1:0], w_mant};
        if (w_ovf) begin
            w_norm_result = {r_sign, EXP_MAX, SAT_MANT};
        end else if (w_unf) begin
            w_norm_result = {r_sign, 31'b0};
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sign   <= 1'b0;
            r_diff   <= '0;
            r_rem    <= '0;
            r_mb     <= '0;
            r_q      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dz   <= 1'b0;
                        r_ovf  <= 1'b0;
                        r_unf  <= 1'b0;
                        r_sign <= w_sign;
                        if (w_b_zero) begin
                            // Divisor zero wins over a zero dividend.
                            r_result <= {w_sign, 8'hFF, 23'b0};
                            r_dz     <= 1'b1;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end else if (w_a_zero) begin
                            r_result <= {w_sign, 31'b0};
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_diff  <= w_diff;
                            r_rem   <= {2'b01, a[MAN_W-1:0]};
                            r_mb    <= {1'b1, b[MAN_W-1:0]};
                            r_q     <= '0;
                            r_cnt   <= CW'(QW - 1);
                            r_busy  <= 1'b1;
                            r_state <= DIVIDE;
                        end
                    end
                end

                DIVIDE: begin
                    // Quotient bits enter at the LSB so the first one ends
                    // up in the MSB after all iterations.
                    r_q   <= {r_q[QW-2:0], w_qbit};
                    r_rem <= w_r_next;
                    if (r_cnt == '0) begin
                        r_state <= NORM;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                NORM: begin
                    r_result <= w_norm_result;
                    r_ovf    <= w_ovf;
                    r_unf    <= w_unf & ~w_ovf;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= DONE;
                end

                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign dz     = r_dz;
    assign ovf    = r_ovf;
    assign unf    = r_unf;

endmodule : fp_div_32
`default_nettype wire

// File: tb/tb_fp_div_32.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_div_32
// Description : Self-checking bench for fp_div_32. A behavioural model based
//               on integer division of the significands predicts every
//               completed result; directed vectors carry hand-computed
//               literal results.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fp_div_32;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        dz;
    logic        ovf;
    logic        unf;

    always #5 clk = ~clk;

    fp_div_32 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .dz     (dz),
        .ovf    (ovf),
        .unf    (unf)
    );

    int          n_cmp = 0;
    int          n_err = 0;

    logic [31:0] exp_result  = '0;
    logic        exp_dz      = 1'b0;
    logic        exp_ovf     = 1'b0;
    logic        exp_unf     = 1'b0;
    logic        exp_valid   = 1'b0;
    logic        prev_done   = 1'b0;
    logic [31:0] prev_result = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Reference: the quotient is the real ratio of the significands, scaled
    // by 2^24 and truncated; then renormalised into [1, 2).
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic f_dz,
                                  output logic f_ovf, output logic f_unf,
                                  output logic f_special);
        logic   s;
        int     ex, ey, e;
        longint mx, my, q;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        f_dz = 1'b0; f_ovf = 1'b0; f_unf = 1'b0; f_special = 1'b0;
        if (ey == 0) begin
            r = {s, 8'hFF, 23'h0}; f_dz = 1'b1; f_special = 1'b1;
        end else if (ex == 0) begin
            r = {s, 31'h0}; f_special = 1'b1;
        end else begin
            mx = longint'({1'b1, x[22:0]});
            my = longint'({1'b1, y[22:0]});
            q  = (mx * 16777216) / my;
            e  = ex - ey + 127;
            if (q >= 16777216) q = q / 2;
            else               e = e - 1;
            if (e >= 255) begin
                r = {s, 8'hFE, 23'h7FFFFF}; f_ovf = 1'b1;
            end else if (e <= 0) begin
                r = {s, 31'h0}; f_unf = 1'b1;
            end else begin
                r = {s, 8'(e), 23'(q)};
            end
        end
    endfunction

    // Compare process: every done pulse is checked against the model, and
    // the cycle after a done must show the pulse gone and the result held.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (prev_done) begin
                chk("done_pulse_width", {31'b0, done}, 32'd0);
                chk("result_hold", result, prev_result);
            end
            if (done && exp_valid) begin
                chk("result", result, exp_result);
                chk("dz", {31'b0, dz}, {31'b0, exp_dz});
                chk("ovf", {31'b0, ovf}, {31'b0, exp_ovf});
                chk("unf", {31'b0, unf}, {31'b0, exp_unf});
                chk("busy_at_done", {31'b0, busy}, 32'd0);
            end
            prev_done   = done;
            prev_result = result;
        end
    end

    // Called right after the accepting edge. disturb: 1 = second start
    // pulse at k+5 with other operands, 2 = operands changed after k.
    task automatic wait_done(input bit hold, input int disturb,
                             output int n, output int busy_cnt, output bit got);
        n = 0; busy_cnt = 0; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            if (!hold) start = (disturb == 1 && n == 4);
            if (disturb != 0) begin
                a = 32'h41200000;   // 10.0
                b = 32'h3F800000;   // 1.0
            end
            @(posedge clk);
            n++;
        end
        if (!hold) start = 1'b0;
    endtask

    task automatic load_expect(input logic [31:0] x, input logic [31:0] y, output logic sp);
        logic [31:0] r;
        logic d, o, u;
        model(x, y, r, d, o, u, sp);
        exp_result = r; exp_dz = d; exp_ovf = o; exp_unf = u; exp_valid = 1'b1;
    endtask

    task automatic run(input string nm, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] lit, input int disturb);
        int   n, bc;
        bit   got;
        logic sp;
        @(negedge clk);
        load_expect(x, y, sp);
        chk({nm, "_model_vs_literal"}, exp_result, lit);
        a = x; b = y; start = 1'b1;
        @(posedge clk);
        wait_done(1'b0, disturb, n, bc, got);
        chk({nm, "_done_seen"}, {31'b0, got}, 32'd1);
        chk({nm, "_latency"}, n, sp ? 32'd0 : 32'd26);
        chk({nm, "_busy_cycles"}, bc, sp ? 32'd0 : 32'd26);
        chk({nm, "_literal"}, result, lit);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"},   {31'b0, busy}, 32'd0);
        chk({nm, "_done"},   {31'b0, done}, 32'd0);
        chk({nm, "_result"}, result,        32'd0);
        chk({nm, "_dz"},     {31'b0, dz},   32'd0);
        chk({nm, "_ovf"},    {31'b0, ovf},  32'd0);
        chk({nm, "_unf"},    {31'b0, unf},  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int   n, bc;
        bit   got;
        logic sp;

        // Reset state
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("post_reset");

        // Main function and boundaries
        run("div_6_2",     32'h40C00000, 32'h40000000, 32'h40400000, 0);
        run("div_1_3",     32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 0);
        run("div_m7p5",    32'hC0F00000, 32'h40200000, 32'hC0400000, 0);
        run("zero_by_5",   32'h00000000, 32'h40A00000, 32'h00000000, 0);
        run("one_by_zero", 32'h3F800000, 32'h00000000, 32'h7F800000, 0);
        run("zero_zero",   32'h00000000, 32'h00000000, 32'h7F800000, 0);
        run("overflow",    32'h7F000000, 32'h00800000, 32'h7F7FFFFF, 0);
        run("underflow",   32'h00800000, 32'h7F000000, 32'h00000000, 0);
        run("one_one",     32'h3F800000, 32'h3F800000, 32'h3F800000, 0);
        run("neg_neg",     32'hBF800000, 32'hC0000000, 32'h3F000000, 0);
        run("negzero_5",   32'h80000000, 32'h40A00000, 32'h80000000, 0);
        run("one_negzero", 32'h3F800000, 32'h80000000, 32'hFF800000, 0);
        run("denorm_a",    32'h00400000, 32'h3F800000, 32'h00000000, 0);

        // Handshake
        run("restart_k5",  32'h40C00000, 32'h40000000, 32'h40400000, 1);
        run("ops_change",  32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 2);

        // start held high across DONE: next accept only from IDLE
        @(negedge clk);
        load_expect(32'h40C00000, 32'h40000000, sp);
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(posedge clk);
        wait_done(1'b1, 0, n, bc, got);
        chk("held_done_seen", {31'b0, got}, 32'd1);
        chk("held_latency", n, 32'd26);
        chk("held_literal", result, 32'h40400000);
        @(posedge clk);                      // DONE -> IDLE, start ignored
        a = 32'h3F800000; b = 32'h40400000;
        load_expect(a, b, sp);
        @(negedge clk);
        chk("held_idle_gap_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);                      // accepted here
        wait_done(1'b0, 0, n, bc, got);
        chk("held2_done_seen", {31'b0, got}, 32'd1);
        chk("held2_latency", n, 32'd26);
        chk("held2_literal", result, 32'h3EAAAAAA);

        // Asynchronous reset mid-operation
        @(negedge clk);
        @(negedge clk);
        load_expect(32'h40C00000, 32'h40000000, sp);
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        exp_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_zero("after_release");
        run("post_rst_6_2", 32'h40C00000, 32'h40000000, 32'h40400000, 0);

        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fp_div_32
`default_nettype wire

// File: doc/fp_div_32.md
Name: fp_div_32

Overview:
Multicycle IEEE-754 single-precision divider, the inverse operation of the team's combinational FP multiplier. It computes a / b with a restoring mantissa divider that produces one quotient bit per clock, so it fits the multicycle datapath without a long combinational path. There is no NaN/Inf input handling, and rounding is truncation (round toward zero), the same as the multiplier. It sits beside the multiplier in the FP execute stage, controlled by a start/busy/done handshake.

Parameters:
QW, 25, quotient bits generated (24-bit significand plus 1 normalisation bit)
BIAS, 127, exponent bias

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  request; sampled only in IDLE
a  in  32  dividend {sign, exp[7:0], mant[22:0]}
b  in  32  divisor
busy  out  1  high from the accepting edge until done is asserted
done  out  1  one-cycle pulse; result is valid from this cycle on
result  out  32  quotient; held until the next accepted start
dz  out  1  divide-by-zero flag; valid with done
ovf  out  1  exponent overflow (saturated); valid with done
unf  out  1  exponent underflow (flushed to zero); valid with done

Behaviour:
- Interface rule (decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset value of every output is 0; state = IDLE. Asserting rst_n low mid-operation aborts the division and discards the partial quotient.
- States:
  - IDLE -> DIVIDE when start=1 and both operands are nonzero.
  - IDLE -> DONE when start=1 and a special case applies.
  - DIVIDE -> NORM after 25 iterations.
  - NORM -> DONE.
  - DONE -> IDLE.
- Zero operand: exponent field 0 counts as zero, so denormals are zero.
- Operand capture (accepting edge):
  - Sign is sa^sb.
  - Significands MA={1,mantA} and MB={1,mantB}.
  - Exponent diff = ea - eb + BIAS, 10-bit signed.
  - Remainder R = MA (25 bits); counter = 24.
- DIVIDE (each cycle): if R >= MB then q bit = 1 and R = R - MB, else q bit = 0; then R <<= 1. Bits are produced MSB first, q[24] down to q[0].
- NORM:
  - If q[24]=1: mant = q[23:1], exp = diff.
  - Else: mant = q[22:0], exp = diff - 1.
  - If exp >= 255: result = {s, 8'hFE, 23'h7FFFFF}, ovf=1.
  - If exp <= 0: result = {s, 31'b0}, unf=1.
  - Remainder bits below q[0] are discarded (truncation).
- Special cases, resolved at the accepting edge:
  - b zero: result = {s, 8'hFF, 23'b0}, dz=1.
  - Otherwise a zero: result = {s, 31'b0}.
  - b zero takes priority over a zero.
- Latency (start sampled at edge k):
  - Normal: result registered at edge k+26, done high in the cycle after it.
  - Special: result registered at edge k, done high in the cycle after it.
- Handshake:
  - busy rises at edge k and falls together with done rising.
  - start while busy or in DONE is ignored; no queuing.
  - The operands are only sampled at edge k, so changes to a and b after it have no effect.
- Flags: dz, ovf and unf are cleared on every accepted start.

Decomposition:
- Package fp_pkg: EXP_W=8, MAN_W=23, BIAS=127, EXP_MAX=8'hFE, SAT_MANT=23'h7FFFFF, and a state enum {IDLE, DIVIDE, NORM, DONE}. The multiplier is to share the field constants.
- One sub-module, fp_div_step: combinational restoring step. Inputs R[24:0] and MB[23:0]; outputs qbit and R_next[24:0]. It is instantiated once and iterated by the FSM.

Test Plan:
- 6.0/2.0: a=0x40C00000, b=0x40000000 -> result=0x40400000; done exactly at edge k+26; flags 0; busy high for 26 cycles.
- 1.0/3.0: a=0x3F800000, b=0x40400000 -> result=0x3EAAAAAA (truncated, not 0x3EAAAAAB). Then -7.5/2.5: 0xC0F00000 / 0x40200000 -> 0xC0400000.
- Specials:
  - 0/5.0: 0x00000000 / 0x40A00000 -> 0x00000000, done in the cycle after edge k.
  - 1.0/0: 0x3F800000 / 0x00000000 -> 0x7F800000, dz=1.
  - 0/0 -> dz=1.
- Range:
  - 0x7F000000 / 0x00800000 -> 0x7F7FFFFF, ovf=1.
  - 0x00800000 / 0x7F000000 -> 0x00000000, unf=1.
- Handshake:
  - Pulse start again at k+5 with different operands: no effect, and the result matches the first operands.
  - Change a and b after edge k: no effect.
  - start held high through DONE: the next operation is accepted only from IDLE.
- Reset:
  - Drop rst_n at k+10 (asynchronously): all outputs 0 immediately, state IDLE.
  - After release, a new 6.0/2.0 completes correctly, with no stale remainder.
